// File: rtl/spi_frame_decoder.sv
// Parses chip-select-framed SPI transactions (command byte + payload) into
// shadow RGBW/intensity registers and commits them atomically when cs deasserts.
module spi_frame_decoder #(
    parameter int          CS_SYNC_STAGES    = 2,
    parameter logic [7:0]  DEFAULT_INTENSITY = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rdy_sig,
    input  logic [7:0] data,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] white,
    output logic [7:0] intensity,
    output logic       update,
    output logic       frame_err
);

    // state   | meaning
    // IDLE    | cs high, waiting for a frame to start
    // CMD     | frame open, expecting the command byte
    // DATA    | valid command seen, payload bytes go to shadows
    // DISCARD | command rejected, ignore bytes until cs rises
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam int NUM_REGS = 5;

    state_t                    state, state_nxt;
    logic [CS_SYNC_STAGES-1:0] cs_sync;
    logic                      cs_s, cs_s_prev;
    logic                      cs_fall, cs_rise;
    logic                      rdy_prev;
    logic                      acc;
    logic                      cmd_valid;
    logic [2:0]                ptr, ptr_nxt;
    logic                      wrote, wrote_nxt;
    logic                      wr_en;
    logic                      commit;
    logic                      err;
    logic [7:0]                shadow     [NUM_REGS];
    logic [7:0]                shadow_nxt [NUM_REGS];

    assign cs_s    = cs_sync[CS_SYNC_STAGES-1];
    assign cs_fall = cs_s_prev & ~cs_s;
    assign cs_rise = ~cs_s_prev & cs_s;
    assign acc     = rdy_sig & ~rdy_prev;

    assign cmd_valid = data[7] && (data[6:3] == 4'b0000) && (data[2:0] <= 3'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync   <= '1;
            cs_s_prev <= 1'b1;
            rdy_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[CS_SYNC_STAGES-2:0], cs};
            cs_s_prev <= cs_s;
            rdy_prev  <= rdy_sig;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= 3'd0;
            wrote <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            wrote <= wrote_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wrote_nxt = wrote;
        wr_en     = 1'b0;
        commit    = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (acc) begin
                    if (cmd_valid) begin
                        ptr_nxt   = data[2:0];
                        wrote_nxt = 1'b0;
                        state_nxt = DATA;
                    end else begin
                        err       = 1'b1;
                        state_nxt = DISCARD;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    wr_en     = 1'b1;
                    wrote_nxt = 1'b1;
                    ptr_nxt   = (ptr == 3'd4) ? 3'd0 : ptr + 3'd1;
                end
                // a byte landing on the same cycle as cs_rise still counts
                if (cs_rise && (wrote || acc)) begin
                    commit = 1'b1;
                end
            end
            DISCARD: begin
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (cs_rise) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            shadow_nxt[i] = shadow[i];
            if (wr_en && (ptr == 3'(i))) begin
                shadow_nxt[i] = data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                shadow[i] <= 8'h00;
            end
            shadow[NUM_REGS-1] <= DEFAULT_INTENSITY;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= shadow_nxt[i];
            end
        end
    end

    // committing from shadow_nxt makes the final same-cycle byte visible
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red       <= 8'h00;
            green     <= 8'h00;
            blue      <= 8'h00;
            white     <= 8'h00;
            intensity <= DEFAULT_INTENSITY;
            update    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (commit) begin
                red       <= shadow_nxt[0];
                green     <= shadow_nxt[1];
                blue      <= shadow_nxt[2];
                white     <= shadow_nxt[3];
                intensity <= shadow_nxt[4];
            end
            update    <= commit;
            frame_err <= err;
        end
    end

endmodule
